// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU memory responder.
package cpu_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    HOLD = 2'b11
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM: registered read, write on we, no reset.
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write strobe, completes after LATENCY
// cycles with a mem_ready pulse. Optional MEM_WRITE_PROTECT_EN rejects low writes.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned PROT_LIMIT = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] PROT_LIM_W = (ADDR_W+1)'(PROT_LIMIT);
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  cnt;

  logic              fire_c;
  logic              wp_c;
  logic              we_c;
  logic [AW-1:0]     ram_addr_c;
  logic [DATA_W-1:0] ram_dout;

  // RAM reads the live address while idle so data is ready even at LATENCY=1.
  assign fire_c     = (state == WAIT) && (cnt == '0);
  assign wp_c       = PROT_EN && (op_q == OP_WR) && ({1'b0, addr_q} < PROT_LIM_W);
  assign we_c       = fire_c && (op_q == OP_WR) && !wp_c;
  assign ram_addr_c = (state == IDLE) ? AW'(addr % DEPTH) : AW'(addr_q % DEPTH);

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk  (clk),
    .we   (we_c),
    .addr (ram_addr_c),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      rdata     <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (read ^ write) begin
            op_q    <= write ? OP_WR : OP_RD;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= LAT_W'(LATENCY - 1);
            busy    <= 1'b1;
            state   <= WAIT;
          end else if (read && write) begin
            err   <= 1'b1;
            state <= HOLD;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            busy      <= 1'b0;
            mem_ready <= 1'b1;
            state     <= DONE;
            if (op_q == OP_RD) rdata <= ram_dout;
            else if (wp_c)     err   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: state <= HOLD;
        // Held strobes must drop before another request is taken.
        HOLD: if (!read && !write) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, random traffic
// against a word-level memory model, reset abort and LATENCY=1 sequences.
module tb_mem_responder;

`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        read0, write0, read1, write1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        mr0, mr1, busy0, busy1, err0, err1;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .LATENCY(2), .PROT_LIMIT(64)) u_dut (
    .clk(clk), .clr(clr), .read(read0), .write(write0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .mem_ready(mr0), .busy(busy0), .err(err0));

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .LATENCY(1), .PROT_LIMIT(64)) u_dut1 (
    .clk(clk), .clr(clr), .read(read1), .write(write1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .mem_ready(mr1), .busy(busy1), .err(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [8:0]  a;
    logic [31:0] d;
    int          hold;
    bit          exp_ready;
    bit          exp_err;
    int          chk;        // 0 none, 1 equal, 2 not equal
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  // Reference memory: word address -> last committed value.
  logic [31:0] mdl [int unsigned];
  int unsigned known[$];
  logic [31:0] exp_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [31:0] got, input logic [31:0] bad);
    n_cmp++;
    if (got === bad) begin
      n_bad++;
      $display("FAIL %s: got %h expected anything else", name, got);
    end
  endtask

  task automatic drive(input int inst, input bit rd, input bit wr,
                       input logic [8:0] a, input logic [31:0] d);
    if (inst == 0) begin
      read0 = rd; write0 = wr; addr0 = a; wdata0 = d;
    end else begin
      read1 = rd; write1 = wr; addr1 = a; wdata1 = d;
    end
  endtask

  // One transaction; k-th bit of each trace is sampled just after accept edge + k.
  task automatic run_access(input int inst, input int lat, input string name,
                            input bit rd, input bit wr, input logic [8:0] a,
                            input logic [31:0] d, input int hold,
                            input bit exp_ready, input bit exp_err,
                            input int chk, input logic [31:0] exp_rdata);
    logic [31:0] g_mr, g_err, g_busy, e_mr, e_err, e_busy, g_rd;
    int w;
    w = ((hold > lat + 1) ? hold : lat + 1) + 3;
    g_mr = '0; g_err = '0; g_busy = '0;
    @(negedge clk);
    drive(inst, rd, wr, a, d);
    for (int k = 0; k < w; k++) begin
      @(posedge clk);
      #1;
      g_mr[k]   = (inst == 0) ? mr0   : mr1;
      g_err[k]  = (inst == 0) ? err0  : err1;
      g_busy[k] = (inst == 0) ? busy0 : busy1;
      if (k >= hold - 1) drive(inst, 1'b0, 1'b0, 9'($urandom), $urandom);
      else               drive(inst, rd, wr, 9'($urandom), $urandom);
    end
    g_rd = (inst == 0) ? rdata0 : rdata1;
    if (exp_ready) begin
      e_mr   = 32'(1) << lat;
      e_busy = (32'(1) << lat) - 32'(1);
      e_err  = exp_err ? e_mr : '0;
    end else begin
      e_mr   = '0;
      e_busy = '0;
      e_err  = exp_err ? 32'(1) : '0;
    end
    check({name, ".ready"}, g_mr, e_mr);
    check({name, ".err"},   g_err, e_err);
    check({name, ".busy"},  g_busy, e_busy);
    if (chk == 1)      check({name, ".rdata"}, g_rd, exp_rdata);
    else if (chk == 2) check_ne({name, ".rdata"}, g_rd, exp_rdata);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    clr = 1'b1;
    #3 clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rdata", rdata0, 32'h0);
    check("rst.flags", {29'h0, mr0, busy0, err0}, 32'h0);
    check("rst1.rdata", rdata1, 32'h0);
    check("rst1.flags", {29'h0, mr1, busy1, err1}, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    //             rd    wr    addr    data          hold rdy   err           chk            exp_rdata
    vecs[0]  = '{1'b0, 1'b1, 9'h0A0, 32'hDEADBEEF, 1,  1'b1, 1'b0,         1,             32'h0};
    vecs[1]  = '{1'b1, 1'b0, 9'h0A0, 32'h0,        1,  1'b1, 1'b0,         1,             32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 9'h040, 32'h0BADC0DE, 1,  1'b1, 1'b0,         1,             32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 9'h040, 32'h0,        1,  1'b1, 1'b0,         1,             32'h0BADC0DE};
    vecs[4]  = '{1'b1, 1'b1, 9'h0A0, 32'h55555555, 2,  1'b0, 1'b1,         1,             32'h0BADC0DE};
    vecs[5]  = '{1'b1, 1'b0, 9'h0A0, 32'h0,        1,  1'b1, 1'b0,         1,             32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 9'h010, 32'h11112222, 2,  1'b1, PROT,         1,             32'hDEADBEEF};
    vecs[7]  = '{1'b1, 1'b0, 9'h010, 32'h0,        10, 1'b1, 1'b0,         PROT ? 2 : 1,  32'h11112222};
    vecs[8]  = '{1'b1, 1'b0, 9'h010, 32'h0,        1,  1'b1, 1'b0,         PROT ? 2 : 1,  32'h11112222};
    vecs[9]  = '{1'b0, 1'b1, 9'h003, 32'hCAFEF00D, 1,  1'b1, PROT,         PROT ? 0 : 1,  32'h11112222};
    vecs[10] = '{1'b1, 1'b0, 9'h003, 32'h0,        1,  1'b1, 1'b0,         PROT ? 2 : 1,  32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 9'h040, 32'h0,        1,  1'b1, 1'b0,         1,             32'h0BADC0DE};
    vecs[12] = '{1'b0, 1'b1, 9'h1FF, 32'h0F0F0F0F, 1,  1'b1, 1'b0,         1,             32'h0BADC0DE};
    vecs[13] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        3,  1'b1, 1'b0,         1,             32'h0F0F0F0F};

    foreach (vecs[i])
      run_access(0, 2, $sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                 vecs[i].hold, vecs[i].exp_ready, vecs[i].exp_err, vecs[i].chk, vecs[i].exp_rdata);

    // Random traffic against the word-level model.
    mdl[9'h0A0] = 32'hDEADBEEF; known.push_back(9'h0A0);
    mdl[9'h040] = 32'h0BADC0DE; known.push_back(9'h040);
    mdl[9'h1FF] = 32'h0F0F0F0F; known.push_back(9'h1FF);
    exp_rd = 32'h0F0F0F0F;
    for (int n = 0; n < 40; n++) begin
      int unsigned sel;
      logic [8:0]  a;
      logic [31:0] d;
      int          h;
      bit          prot_hit;
      sel = $urandom_range(7);
      d   = $urandom;
      h   = $urandom_range(4, 1);
      if (sel == 0) begin
        a = 9'($urandom);
        run_access(0, 2, $sformatf("rnd%0d.coll", n), 1'b1, 1'b1, a, d, h, 1'b0, 1'b1, 1, exp_rd);
      end else if (sel <= 3) begin
        a = 9'($urandom);
        prot_hit = PROT && (a < 9'd64);
        if (!prot_hit) begin
          if (!mdl.exists(a)) known.push_back(a);
          mdl[a] = d;
        end
        run_access(0, 2, $sformatf("rnd%0d.wr", n), 1'b0, 1'b1, a, d, h, 1'b1, prot_hit, 1, exp_rd);
      end else begin
        a = 9'(known[$urandom_range(known.size() - 1)]);
        exp_rd = mdl[a];
        run_access(0, 2, $sformatf("rnd%0d.rd", n), 1'b1, 1'b0, a, 32'h0, h, 1'b1, 1'b0, 1, exp_rd);
      end
    end

    // Reset during WAIT of a write: outputs clear at once, write never lands.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'h1FF, 32'h12345678);
    @(posedge clk);
    #1;
    check("abort.busy_before", {31'h0, busy0}, 32'h1);
    #2 clr = 1'b0;
    #1;
    check("abort.rdata", rdata0, 32'h0);
    check("abort.ready", {31'h0, mr0}, 32'h0);
    check("abort.busy", {31'h0, busy0}, 32'h0);
    check("abort.err", {31'h0, err0}, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    run_access(0, 2, "abort.readback", 1'b1, 1'b0, 9'h1FF, 32'h0, 1, 1'b1, 1'b0, 1, mdl[9'h1FF]);

    // LATENCY=1 instance, including the top word.
    run_access(1, 1, "lat1.wr000", 1'b0, 1'b1, 9'h000, 32'hA1A1A1A1, 1, 1'b1, PROT, 1, 32'h0);
    run_access(1, 1, "lat1.wr1ff", 1'b0, 1'b1, 9'h1FF, 32'hB2B2B2B2, 1, 1'b1, 1'b0, 1, 32'h0);
    run_access(1, 1, "lat1.rd000", 1'b1, 1'b0, 9'h000, 32'h0, 1, 1'b1, 1'b0,
               PROT ? 2 : 1, 32'hA1A1A1A1);
    run_access(1, 1, "lat1.rd1ff", 1'b1, 1'b0, 9'h1FF, 32'h0, 1, 1'b1, 1'b0, 1, 32'hB2B2B2B2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
